// File: rtl/mix_columns_iter_if.sv
// mix_columns_iter_if
//   Bundles the state transfer between a producer (master) and the
//   mix_columns_iter block (slave).
//
//   Handshake semantics (both channels): a transfer occurs on a rising clk_i
//   edge where valid and ready are both 1. A producer that raises valid keeps
//   it raised, with payload and mode bits stable, until that transfer. Ready
//   may change freely and never depends on valid in the same cycle.
//
//   Signals (names are from the slave's point of view)
//     fwd_ninv_i   1    1 = MixColumns, 0 = InvMixColumns (input payload)
//     bypass_i     1    1 = pass the state through unchanged (input payload)
//     in_valid_i   1    input channel valid
//     in_ready_o   1    input channel ready
//     in_state_i   128  input state
//     out_valid_o  1    output channel valid
//     out_ready_i  1    output channel ready
//     out_state_o  128  output state
interface mix_columns_iter_if;
   logic         fwd_ninv_i;
   logic         bypass_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [127:0] in_state_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [127:0] out_state_o;

   modport slave (
      input  fwd_ninv_i,
      input  bypass_i,
      input  in_valid_i,
      output in_ready_o,
      input  in_state_i,
      output out_valid_o,
      input  out_ready_i,
      output out_state_o
   );

   modport master (
      output fwd_ninv_i,
      output bypass_i,
      output in_valid_i,
      input  in_ready_o,
      output in_state_i,
      input  out_valid_o,
      output out_ready_i,
      input  out_state_o
   );
endinterface

// File: rtl/mix_columns_iter.sv
// mix_columns_iter
//   Iterative AES MixColumns / InvMixColumns stage. A captured 128-bit state
//   is transformed in place, COLS_PER_CYCLE columns per clock, then offered
//   on the output channel. Bypass sends the captured state straight to DONE.
//   Byte i = state[8i+7:8i]; column c = bytes 4c..4c+3; row r = byte 4c+r.
//
//   Parameters
//     COLS_PER_CYCLE  columns per clock: 1, 2 or 4
//   Ports
//     clk_i          clock, rising edge
//     rst_i          synchronous active-high reset
//     bus            mix_columns_iter_if.slave (state in / result out)
//     dbg_state_o    FSM state (0 IDLE, 1 BUSY, 2 DONE)
//     dbg_col_cnt_o  index of the next column to transform
//     dbg_mode_o     captured mode bits {bypass, fwd_ninv}
module mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   mix_columns_iter_if.slave   bus,
   output logic [1:0]          dbg_state_o,
   output logic [1:0]          dbg_col_cnt_o,
   output logic [1:0]          dbg_mode_o
);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
         $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   // Column counter advances modulo 4; for COLS_PER_CYCLE=4 the step is 0
   // and the single BUSY cycle is also the last one.
   localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_q;
   logic [1:0]   col_cnt_q;
   logic         fwd_q;
   logic         byp_q;
   logic         out_valid_q;
   logic [127:0] work_q;

   logic [127:0] work_next;
   logic [1:0]   col_cnt_next;
   logic [1:0]   col_idx;
   logic         last_step;

   // ---------------------------------------------------------------
   // GF(2^8) helpers, reduction polynomial 0x11B
   // ---------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // One output row: x0 is the row's own byte, x1..x3 the following rows.
   function automatic logic [7:0] mix_byte(input logic [7:0] x0, input logic [7:0] x1,
                                           input logic [7:0] x2, input logic [7:0] x3,
                                           input logic       fwd);
      logic [7:0] x0_2, x0_4, x0_8;
      logic [7:0] x1_2, x1_4, x1_8;
      logic [7:0] x2_2, x2_4, x2_8;
      logic [7:0] x3_2, x3_4, x3_8;
      x0_2 = xtime(x0); x0_4 = xtime(x0_2); x0_8 = xtime(x0_4);
      x1_2 = xtime(x1); x1_4 = xtime(x1_2); x1_8 = xtime(x1_4);
      x2_2 = xtime(x2); x2_4 = xtime(x2_2); x2_8 = xtime(x2_4);
      x3_2 = xtime(x3); x3_4 = xtime(x3_2); x3_8 = xtime(x3_4);
      if (fwd) begin
         // 2*x0 ^ 3*x1 ^ x2 ^ x3
         return x0_2 ^ x1_2 ^ x1 ^ x2 ^ x3;
      end
      // 0E*x0 ^ 0B*x1 ^ 0D*x2 ^ 09*x3
      return (x0_8 ^ x0_4 ^ x0_2) ^ (x1_8 ^ x1_2 ^ x1) ^
             (x2_8 ^ x2_4 ^ x2)   ^ (x3_8 ^ x3);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic fwd);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[7:0];
      a1 = col[15:8];
      a2 = col[23:16];
      a3 = col[31:24];
      return {mix_byte(a3, a0, a1, a2, fwd),
              mix_byte(a2, a3, a0, a1, fwd),
              mix_byte(a1, a2, a3, a0, fwd),
              mix_byte(a0, a1, a2, a3, fwd)};
   endfunction

   // ---------------------------------------------------------------
   // Next work register: transform the current group of columns in place
   // ---------------------------------------------------------------
   always_comb begin
      work_next = work_q;
      col_idx   = col_cnt_q;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         col_idx = col_cnt_q + 2'(k);
         work_next[{col_idx, 5'b0} +: 32] = mix_col(work_q[{col_idx, 5'b0} +: 32], fwd_q);
      end
   end

   assign col_cnt_next = col_cnt_q + STEP;
   assign last_step    = (col_cnt_next == 2'd0);

   // ---------------------------------------------------------------
   // Control FSM and work register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         col_cnt_q   <= 2'd0;
         fwd_q       <= 1'b0;
         byp_q       <= 1'b0;
         out_valid_q <= 1'b0;
         work_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid_i) begin
                  work_q    <= bus.in_state_i;
                  fwd_q     <= bus.fwd_ninv_i;
                  byp_q     <= bus.bypass_i;
                  col_cnt_q <= 2'd0;
                  if (bus.bypass_i) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               work_q    <= work_next;
               col_cnt_q <= col_cnt_next;
               if (last_step) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               // Result held untouched until the consumer takes it.
               if (bus.out_ready_i) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready_o  = (state_q == IDLE);
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_state_o = work_q;

   assign dbg_state_o   = state_q;
   assign dbg_col_cnt_o = col_cnt_q;
   assign dbg_mode_o    = {byp_q, fwd_q};

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter
//   Bench for mix_columns_iter. Three instances (COLS_PER_CYCLE 1, 2, 4)
//   share the stimulus; sel routes the handshake to one instance at a time.
module tb_mix_columns_iter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // ---------------- shared stimulus ----------------
   int           sel;
   logic         tb_valid;
   logic         tb_fwd;
   logic         tb_byp;
   logic         tb_ready;
   logic [127:0] tb_state;

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_iter_if bus ();
      logic [1:0] dbg_state;
      logic [1:0] dbg_col_cnt;
      logic [1:0] dbg_mode;

      assign bus.in_valid_i  = tb_valid && (sel == g);
      assign bus.out_ready_i = tb_ready && (sel == g);
      assign bus.fwd_ninv_i  = tb_fwd;
      assign bus.bypass_i    = tb_byp;
      assign bus.in_state_i  = tb_state;

      mix_columns_iter #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
         .clk_i         (clk),
         .rst_i         (rst),
         .bus           (bus),
         .dbg_state_o   (dbg_state),
         .dbg_col_cnt_o (dbg_col_cnt),
         .dbg_mode_o    (dbg_mode)
      );
   end

   logic         cur_ready;
   logic         cur_valid;
   logic [127:0] cur_state;
   logic [5:0]   cur_dbg;

   always_comb begin
      cur_ready = g_dut[0].bus.in_ready_o;
      cur_valid = g_dut[0].bus.out_valid_o;
      cur_state = g_dut[0].bus.out_state_o;
      cur_dbg   = {g_dut[0].dbg_state, g_dut[0].dbg_col_cnt, g_dut[0].dbg_mode};
      case (sel)
         1: begin
            cur_ready = g_dut[1].bus.in_ready_o;
            cur_valid = g_dut[1].bus.out_valid_o;
            cur_state = g_dut[1].bus.out_state_o;
            cur_dbg   = {g_dut[1].dbg_state, g_dut[1].dbg_col_cnt, g_dut[1].dbg_mode};
         end
         2: begin
            cur_ready = g_dut[2].bus.in_ready_o;
            cur_valid = g_dut[2].bus.out_valid_o;
            cur_state = g_dut[2].bus.out_state_o;
            cur_dbg   = {g_dut[2].dbg_state, g_dut[2].dbg_col_cnt, g_dut[2].dbg_mode};
         end
         default: ;
      endcase
   end

   // ---------------- reference model ----------------
   // General GF(2^8) multiply: carry-less product, then reduce by 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
      return p[7:0];
   endfunction

   // Matrix row coefficients, k = 0..3 applied to a_(r+k).
   function automatic logic [127:0] ref_model(input logic [127:0] s, input logic fwd,
                                              input logic byp);
      logic [31:0]  coef;
      logic [127:0] r;
      logic [7:0]   b;
      if (byp) return s;
      coef = fwd ? {8'h01, 8'h01, 8'h03, 8'h02} : {8'h09, 8'h0D, 8'h0B, 8'h0E};
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            b = 8'h00;
            for (int k = 0; k < 4; k++)
               b = b ^ gmul(coef[8*k +: 8], s[32*c + 8*((row + k) % 4) +: 8]);
            r[32*c + 8*row +: 8] = b;
         end
      return r;
   endfunction

   function automatic int cpc_of(input int s);
      return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
   endfunction

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cpc=%0d): got %h expected %h", name, cpc_of(sel), act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- vector driver ----------------
   typedef struct {
      logic [127:0] in_s;
      logic         fwd;
      logic         byp;
      logic [127:0] exp_s;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v, input int exp_lat);
      int n;
      int lat;
      tb_state = v.in_s;
      tb_fwd   = v.fwd;
      tb_byp   = v.byp;
      tb_valid = 1'b1;
      tb_ready = 1'b1;
      n = 0;
      while (!cur_ready && n < 50) begin
         cycle();
         n++;
      end
      check("vec_in_ready", 128'(cur_ready), 128'(1));
      cycle();                          // accept edge
      // Mode and data changes after the accept must not affect the result.
      tb_valid = 1'b0;
      tb_fwd   = ~v.fwd;
      tb_byp   = ~v.byp;
      tb_state = rnd128();
      lat = 1;
      while (!cur_valid && lat < 20) begin
         cycle();
         lat++;
      end
      check("vec_latency", 128'(lat), 128'(exp_lat));
      check("vec_state", cur_state, v.exp_s);
      cycle();                          // output handshake
      check("vec_idle_after", 128'({cur_ready, cur_valid}), 128'(2'b10));
   endtask

   // ---------------- scoreboard ----------------
   logic [127:0] exp_q[$];
   logic [127:0] orig_q[$];
   logic [1:0]   mode_q[$];

   task automatic run_random(input int num);
      int n_acc;
      int n_out;
      int budget;
      logic [127:0] e, o, got;
      logic [1:0]   m;
      n_acc  = 0;
      n_out  = 0;
      budget = 0;
      while ((n_acc < num || exp_q.size() != 0) && budget < 25000) begin
         tb_ready = ($urandom_range(0, 2) != 0);
         if (n_acc < num) begin
            tb_valid = ($urandom_range(0, 3) != 0);
            tb_state = rnd128();
            tb_fwd   = 1'($urandom_range(0, 1));
            tb_byp   = ($urandom_range(0, 7) == 0);
         end else begin
            tb_valid = 1'b0;
         end
         if (tb_valid && cur_ready) begin
            exp_q.push_back(ref_model(tb_state, tb_fwd, tb_byp));
            orig_q.push_back(tb_state);
            mode_q.push_back({tb_byp, tb_fwd});
            n_acc++;
         end
         if (cur_valid && tb_ready) begin
            got = cur_state;
            if (exp_q.size() == 0) begin
               check("rnd_extra_output", 128'(1), 128'(0));
            end else begin
               e = exp_q.pop_front();
               o = orig_q.pop_front();
               m = mode_q.pop_front();
               check("rnd_state", got, e);
               if (!m[1]) check("rnd_roundtrip", ref_model(got, ~m[0], 1'b0), o);
            end
            n_out++;
         end
         cycle();
         budget++;
      end
      tb_valid = 1'b0;
      check("rnd_budget", 128'(budget < 25000), 128'(1));
      check("rnd_count", 128'(n_out), 128'(num));
      exp_q.delete();
      orig_q.delete();
      mode_q.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [127:0] e;
      int           n;

      vecs[0] = '{{96'h0, 32'h455313DB}, 1'b1, 1'b0, {96'h0, 32'hBCA14D8E}};
      vecs[1] = '{{96'h0, 32'hBCA14D8E}, 1'b0, 1'b0, {96'h0, 32'h455313DB}};
      vecs[2] = '{{32'hC6C6C6C6, 32'hD5D4D4D4, 32'h5C220AF2, 32'h455313DB}, 1'b1, 1'b0,
                  {32'hC6C6C6C6, 32'hD6D7D5D5, 32'h9D58DC9F, 32'hBCA14D8E}};
      vecs[3] = '{{32'hC6C6C6C6, 32'hD6D7D5D5, 32'h9D58DC9F, 32'hBCA14D8E}, 1'b0, 1'b0,
                  {32'hC6C6C6C6, 32'hD5D4D4D4, 32'h5C220AF2, 32'h455313DB}};
      vecs[4] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b1,
                  128'h00112233_44556677_8899AABB_CCDDEEFF};
      vecs[5] = '{{32'hC6C6C6C6, 32'hD5D4D4D4, 32'h5C220AF2, 32'h455313DB}, 1'b0, 1'b1,
                  {32'hC6C6C6C6, 32'hD5D4D4D4, 32'h5C220AF2, 32'h455313DB}};

      sel      = 0;
      tb_valid = 1'b0;
      tb_fwd   = 1'b0;
      tb_byp   = 1'b0;
      tb_ready = 1'b0;
      tb_state = '0;
      rst      = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;

      // Reset state of every instance.
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("rst_in_ready", 128'(cur_ready), 128'(1));
         check("rst_out_valid", 128'(cur_valid), 128'(0));
         check("rst_out_state", cur_state, 128'(0));
         check("rst_dbg", 128'(cur_dbg), 128'(0));
      end

      // Known-answer vectors on each column width.
      for (int s = 0; s < 3; s++) begin
         sel = s;
         for (int i = 0; i < 6; i++)
            run_vec(vecs[i], vecs[i].byp ? 1 : (4 / cpc_of(s) + 1));
      end

      // Backpressure: result held for 10 cycles while input side toggles.
      sel      = 0;
      tb_ready = 1'b0;
      tb_state = rnd128();
      tb_fwd   = 1'b1;
      tb_byp   = 1'b0;
      e        = ref_model(tb_state, 1'b1, 1'b0);
      tb_valid = 1'b1;
      cycle();
      tb_valid = 1'b0;
      n = 0;
      while (!cur_valid && n < 20) begin
         cycle();
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         tb_valid = 1'($urandom_range(0, 1));
         tb_state = rnd128();
         tb_fwd   = 1'($urandom_range(0, 1));
         cycle();
         check("bp_state", cur_state, e);
         check("bp_in_ready", 128'(cur_ready), 128'(0));
         check("bp_out_valid", 128'(cur_valid), 128'(1));
      end
      tb_valid = 1'b0;
      tb_ready = 1'b1;
      cycle();
      check("bp_release", 128'({cur_ready, cur_valid}), 128'(2'b10));

      // Reset in the middle of BUSY with col_cnt = 2.
      tb_state = rnd128();
      tb_fwd   = 1'b1;
      tb_byp   = 1'b0;
      tb_valid = 1'b1;
      cycle();                          // accept
      tb_valid = 1'b0;
      cycle();                          // column 0
      cycle();                          // column 1
      check("mid_busy_dbg", 128'(cur_dbg[5:2]), 128'(4'b0110));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("mid_rst_out_valid", 128'(cur_valid), 128'(0));
      check("mid_rst_out_state", cur_state, 128'(0));
      check("mid_rst_in_ready", 128'(cur_ready), 128'(1));
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("mid_rst_no_stale", 128'(cur_valid), 128'(0));
      end

      // Random traffic on each column width.
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         run_random(1000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
